// File: rtl/uart_bus_bridge.sv
// Serial-to-bus initiator: decodes read/write command frames from a UART receiver, runs one
// 32-bit bus transaction per frame and returns an ACK/NAK byte stream to the UART transmitter.
module uart_bus_bridge #(
  parameter int unsigned TimeoutCycles = 100000
) (
  input  logic        clk,
  input  logic        nReset,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  input  logic        rx_err,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_busy,
  input  logic        tx_done,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_wen,
  output logic        bus_ren,
  input  logic [31:0] bus_rdata,
  input  logic        bus_request_stall,
  input  logic        bus_error,
  output logic        active,
  output logic        dropped
);

  typedef enum logic [2:0] {StIdle, StAddr, StData, StBus, StResp} state_e;

  localparam logic [7:0]  CmdWrite    = 8'h57;
  localparam logic [7:0]  CmdRead     = 8'h52;
  localparam logic [7:0]  RespAck     = 8'h06;
  localparam logic [7:0]  RespNak     = 8'h15;
  localparam logic [31:0] TimeoutLast = 32'(TimeoutCycles) - 32'd1;

  state_e      state_q, state_d;
  logic        is_write_q, is_write_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] addr_sh_q, addr_sh_d;
  logic [31:0] wdata_sh_q, wdata_sh_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic        bus_wen_q, bus_wen_d;
  logic        bus_ren_q, bus_ren_d;
  logic [39:0] resp_q, resp_d;
  logic [2:0]  left_q, left_d;
  logic        pending_q, pending_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        dropped_q, dropped_d;
  logic        active_q, active_d;

  always_comb begin
    state_d     = state_q;
    is_write_d  = is_write_q;
    cnt_d       = cnt_q;
    timer_d     = timer_q;
    addr_sh_d   = addr_sh_q;
    wdata_sh_d  = wdata_sh_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wen_d   = bus_wen_q;
    bus_ren_d   = bus_ren_q;
    resp_d      = resp_q;
    left_d      = left_q;
    pending_d   = pending_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = 1'b0;
    dropped_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (rx_done && !rx_err) begin
          if (rx_data == CmdWrite || rx_data == CmdRead) begin
            state_d    = StAddr;
            is_write_d = (rx_data == CmdWrite);
            cnt_d      = 2'd0;
            timer_d    = '0;
          end else begin
            state_d = StResp;
            resp_d  = {RespNak, 32'h0};
            left_d  = 3'd1;
          end
        end
      end
      StAddr, StData: begin
        if (rx_done) begin
          timer_d = '0;
          if (rx_err) begin
            state_d = StResp;
            resp_d  = {RespNak, 32'h0};
            left_d  = 3'd1;
          end else begin
            cnt_d = cnt_q + 2'd1;
            if (state_q == StAddr) addr_sh_d = {addr_sh_q[23:0], rx_data};
            else                   wdata_sh_d = {wdata_sh_q[23:0], rx_data};
            if (cnt_q == 2'd3) begin
              if (state_q == StAddr && is_write_q) begin
                state_d = StData;
              end else begin
                state_d    = StBus;
                bus_addr_d = addr_sh_d;
                if (is_write_q) bus_wdata_d = wdata_sh_d;
                bus_wen_d  = is_write_q;
                bus_ren_d  = !is_write_q;
              end
            end
          end
        end else if (TimeoutCycles != 0 && timer_q == TimeoutLast) begin
          state_d = StIdle;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      StBus: begin
        if (rx_done) dropped_d = 1'b1;
        if (!bus_request_stall) begin
          bus_wen_d = 1'b0;
          bus_ren_d = 1'b0;
          state_d   = StResp;
          if (bus_error) begin
            resp_d = {RespNak, 32'h0};
            left_d = 3'd1;
          end else if (is_write_q) begin
            resp_d = {RespAck, 32'h0};
            left_d = 3'd1;
          end else begin
            resp_d = {RespAck, bus_rdata};
            left_d = 3'd5;
          end
        end
      end
      StResp: begin
        if (rx_done) dropped_d = 1'b1;
        if (tx_done && pending_q && left_q == 3'd0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Launch from the next-state view so the first byte leaves the cycle after the decision.
    if (tx_done) pending_d = 1'b0;
    if (state_d == StResp && !pending_d && left_d != 3'd0 && !tx_busy) begin
      tx_valid_d = 1'b1;
      tx_data_d  = resp_d[39:32];
      resp_d     = {resp_d[31:0], 8'h00};
      left_d     = left_d - 3'd1;
      pending_d  = 1'b1;
    end

    active_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= StIdle;
      is_write_q  <= 1'b0;
      cnt_q       <= 2'd0;
      timer_q     <= '0;
      addr_sh_q   <= '0;
      wdata_sh_q  <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wen_q   <= 1'b0;
      bus_ren_q   <= 1'b0;
      resp_q      <= '0;
      left_q      <= 3'd0;
      pending_q   <= 1'b0;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      dropped_q   <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_write_q  <= is_write_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      addr_sh_q   <= addr_sh_d;
      wdata_sh_q  <= wdata_sh_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wen_q   <= bus_wen_d;
      bus_ren_q   <= bus_ren_d;
      resp_q      <= resp_d;
      left_q      <= left_d;
      pending_q   <= pending_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      dropped_q   <= dropped_d;
      active_q    <= active_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_wen   = bus_wen_q;
  assign bus_ren   = bus_ren_q;
  assign active    = active_q;
  assign dropped   = dropped_q;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Bench for uart_bus_bridge: host, bus target and UART transmitter models with a frame-level
// reference that predicts the response bytes and bus transaction of every command frame.
module tb_uart_bus_bridge;

  localparam int unsigned Timeout = 50;

  logic        clk = 1'b0;
  logic        nReset;
  logic [7:0]  rx_data;
  logic        rx_done, rx_err;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_busy, tx_done;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_wen, bus_ren, bus_request_stall, bus_error;
  logic        active, dropped;

  always #5 clk = ~clk;

  uart_bus_bridge #(.TimeoutCycles(Timeout)) dut (
    .clk               (clk),
    .nReset            (nReset),
    .rx_data           (rx_data),
    .rx_done           (rx_done),
    .rx_err            (rx_err),
    .tx_data           (tx_data),
    .tx_valid          (tx_valid),
    .tx_busy           (tx_busy),
    .tx_done           (tx_done),
    .bus_addr          (bus_addr),
    .bus_wdata         (bus_wdata),
    .bus_wen           (bus_wen),
    .bus_ren           (bus_ren),
    .bus_rdata         (bus_rdata),
    .bus_request_stall (bus_request_stall),
    .bus_error         (bus_error),
    .active            (active),
    .dropped           (dropped)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [7:0]  tx_q[$];
  bit          bq_we[$];
  logic [31:0] bq_addr[$];
  logic [31:0] bq_wdata[$];
  int          bq_len[$];
  int          comp_cyc, first_valid_cyc, last_done_cyc, last_rx_cyc;
  int          tx_gap, tx_overlap, tx_left;
  int          stall_cfg, tx_dur_cfg;
  logic [31:0] last_addr = '0;
  logic [31:0] last_wdata = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Bus target: stalls each request for stall_cfg cycles, logs completed transactions.
  initial begin
    int req_cyc, stall_left;
    req_cyc = 0;
    stall_left = 0;
    bus_request_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_wen || bus_ren) begin
        if (req_cyc == 0) stall_left = stall_cfg;
        req_cyc++;
        if (stall_left > 0) begin
          bus_request_stall = 1'b1;
          stall_left--;
        end else begin
          bus_request_stall = 1'b0;
          bq_we.push_back(bus_wen);
          bq_addr.push_back(bus_addr);
          bq_wdata.push_back(bus_wdata);
          bq_len.push_back(req_cyc);
          comp_cyc = cyc;
        end
      end else begin
        req_cyc = 0;
        bus_request_stall = 1'b0;
      end
    end
  end

  // UART transmitter: each byte stays busy for a few cycles, then tx_done pulses.
  initial begin
    tx_busy = 1'b0;
    tx_done = 1'b0;
    tx_left = 0;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (!nReset) begin
        tx_busy = 1'b0;
        tx_left = 0;
      end else begin
        if (tx_left > 0) begin
          tx_left--;
          if (tx_left == 0) begin
            tx_done = 1'b1;
            tx_busy = 1'b0;
            last_done_cyc = cyc;
          end
        end
        if (tx_valid) begin
          if (tx_busy) tx_overlap++;
          if (tx_q.size() > 0 && cyc != last_done_cyc + 1) tx_gap++;
          if (tx_q.size() == 0) first_valid_cyc = cyc;
          tx_q.push_back(tx_data);
          tx_busy = 1'b1;
          tx_left = (tx_dur_cfg > 0) ? tx_dur_cfg : int'($urandom_range(1, 4));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit err, output bit drop);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    rx_err = err;
    last_rx_cyc = cyc;
    @(negedge clk);
    rx_done = 1'b0;
    rx_err = 1'b0;
    drop = dropped;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!active) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // err_idx: index of the byte carrying rx_err (-1 for none).
  task automatic run_frame(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int err_idx, input int stall,
                           input bit berr, input bit poke);
    logic [7:0] bytes[9];
    logic [7:0] exp_tx[$];
    bit is_wr, is_rd, bus_exp, drop, any_drop, ok;
    int n, bad_cyc;
    is_wr = (cmd == 8'h57);
    is_rd = (cmd == 8'h52);
    n = is_wr ? 9 : (is_rd ? 5 : 1);
    bytes[0] = cmd;
    for (int i = 0; i < 4; i++) begin
      bytes[1 + i] = addr[31 - 8 * i -: 8];
      bytes[5 + i] = wdata[31 - 8 * i -: 8];
    end
    bus_rdata = rdata;
    bus_error = berr;
    stall_cfg = stall;
    tx_dur_cfg = poke ? 8 : 0;
    tx_q.delete();
    bq_we.delete();
    bq_addr.delete();
    bq_wdata.delete();
    bq_len.delete();
    tx_gap = 0;
    tx_overlap = 0;

    bus_exp = (is_wr || is_rd) && !(err_idx >= 1 && err_idx < n);
    if (!bus_exp || berr) exp_tx = '{8'h15};
    else if (is_wr)       exp_tx = '{8'h06};
    else exp_tx = '{8'h06, rdata[31:24], rdata[23:16], rdata[15:8], rdata[7:0]};

    any_drop = 1'b0;
    for (int i = 0; i < n; i++) begin
      send_byte(bytes[i], i == err_idx, drop);
      any_drop |= drop;
      if (i == err_idx) break;
    end
    bad_cyc = last_rx_cyc;
    check_eq("rx_no_drop", 32'(any_drop), 32'd0);

    if (poke) begin
      for (int k = 0; k < 1000; k++) begin
        if (tx_q.size() > 0) break;
        @(negedge clk);
      end
      send_byte(8'hA5, 1'b0, drop);
      check_eq("dropped_pulse", 32'(drop), 32'd1);
    end

    wait_idle(ok);
    check_eq("back_to_idle", 32'(ok), 32'd1);
    check_eq("tx_len", 32'(tx_q.size()), 32'(exp_tx.size()));
    for (int i = 0; i < tx_q.size() && i < exp_tx.size(); i++)
      check_eq($sformatf("tx_byte%0d", i), 32'(tx_q[i]), 32'(exp_tx[i]));
    check_eq("tx_gap", 32'(tx_gap), 32'd0);
    check_eq("tx_overlap", 32'(tx_overlap), 32'd0);
    check_eq("bus_count", 32'(bq_we.size()), 32'(bus_exp));

    if (bus_exp && bq_we.size() > 0) begin
      check_eq("bus_is_write", 32'(bq_we[0]), 32'(is_wr));
      check_eq("bus_addr", bq_addr[0], addr);
      if (is_wr) check_eq("bus_wdata", bq_wdata[0], wdata);
      check_eq("req_cycles", 32'(bq_len[0]), 32'(stall + 1));
      if (tx_q.size() > 0) check_eq("tx_first_after_bus", 32'(first_valid_cyc), 32'(comp_cyc + 1));
      last_addr = addr;
      if (is_wr) last_wdata = wdata;
    end else if (tx_q.size() > 0) begin
      check_eq("nak_first_latency", 32'(first_valid_cyc), 32'(bad_cyc + 1));
    end
    check_eq("addr_hold", bus_addr, last_addr);
    check_eq("wdata_hold", bus_wdata, last_wdata);
  endtask

  task automatic timeout_test();
    bit drop;
    int cnt;
    tx_q.delete();
    send_byte(8'h57, 1'b0, drop);
    send_byte(8'h00, 1'b0, drop);
    send_byte(8'h00, 1'b0, drop);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cnt++;
      if (!active) break;
    end
    check_eq("timeout_cycles", 32'(cnt), 32'(Timeout));
    check_eq("timeout_no_tx", 32'(tx_q.size()), 32'd0);
    check_eq("timeout_addr_hold", bus_addr, last_addr);
  endtask

  task automatic idle_err_test();
    bit drop;
    tx_q.delete();
    send_byte(8'h57, 1'b1, drop);
    repeat (3) @(negedge clk);
    check_eq("idle_err_active", 32'(active), 32'd0);
    check_eq("idle_err_no_tx", 32'(tx_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_tx_data"}, 32'(tx_data), 32'd0);
    check_eq({pfx, "_tx_valid"}, 32'(tx_valid), 32'd0);
    check_eq({pfx, "_bus_addr"}, bus_addr, 32'd0);
    check_eq({pfx, "_bus_wdata"}, bus_wdata, 32'd0);
    check_eq({pfx, "_bus_wen"}, 32'(bus_wen), 32'd0);
    check_eq({pfx, "_bus_ren"}, 32'(bus_ren), 32'd0);
    check_eq({pfx, "_active"}, 32'(active), 32'd0);
    check_eq({pfx, "_dropped"}, 32'(dropped), 32'd0);
  endtask

  task automatic reset_in_bus_test();
    bit drop;
    stall_cfg = 30;
    tx_dur_cfg = 0;
    send_byte(8'h52, 1'b0, drop);
    send_byte(8'h00, 1'b0, drop);
    send_byte(8'h00, 1'b0, drop);
    send_byte(8'h00, 1'b0, drop);
    send_byte(8'h04, 1'b0, drop);
    check_eq("pre_reset_ren", 32'(bus_ren), 32'd1);
    nReset = 1'b0;
    #1;
    check_reset_outputs("bus_reset");
    @(negedge clk);
    nReset = 1'b1;
    stall_cfg = 0;
    last_addr = '0;
    last_wdata = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed time-out, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] cmd;
    int r, err_idx;
    nReset = 1'b0;
    rx_data = 8'h00;
    rx_done = 1'b0;
    rx_err = 1'b0;
    bus_rdata = '0;
    bus_error = 1'b0;
    stall_cfg = 0;
    tx_dur_cfg = 0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    nReset = 1'b1;

    run_frame(8'h57, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, -1, 0, 1'b0, 1'b0);
    run_frame(8'h52, 32'h0000_0008, 32'h0, 32'h1234_5678, -1, 3, 1'b0, 1'b0);
    run_frame(8'h57, 32'h0000_0020, 32'hCAFE_F00D, 32'h0, -1, 1, 1'b1, 1'b0);
    run_frame(8'h52, 32'h0000_0030, 32'h0, 32'hA5C3_0F96, -1, 0, 1'b0, 1'b0);
    run_frame(8'h41, 32'h0, 32'h0, 32'h0, -1, 0, 1'b0, 1'b0);
    run_frame(8'h52, 32'h4433_2211, 32'h0, 32'h0, 3, 0, 1'b0, 1'b0);
    timeout_test();
    run_frame(8'h52, 32'h0000_0040, 32'h0, 32'h0BAD_F00D, -1, 2, 1'b0, 1'b1);
    idle_err_test();
    run_frame(8'h57, 32'h1000_0004, 32'h0102_0304, 32'h0, -1, 0, 1'b0, 1'b0);
    reset_in_bus_test();
    run_frame(8'h52, 32'h0000_0044, 32'h0, 32'h5566_7788, -1, 0, 1'b0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      r = int'($urandom_range(0, 7));
      cmd = (r < 3) ? 8'h57 : (r < 6) ? 8'h52 : 8'($urandom);
      err_idx = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 8)) : -1;
      run_frame(cmd, $urandom, $urandom, $urandom, err_idx, int'($urandom_range(0, 5)),
                $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_bus_bridge.md
# uart_bus_bridge

UART-side bus initiator: decodes a byte-serial command stream from the UART receiver and issues single 32-bit read/write transactions on the bus as initiator. Responses go back as a byte stream to the UART transmitter. It is the counterpart of the UART peripheral: an external host uses it to drive peripheral registers through a serial link. It sits between `UartRxEn`/`UartTxEn` instances and the bus (e.g., as debug/boot loader master).

## Interface
- `TimeoutCycles`, default 100000: idle cycles allowed between bytes of one frame before the frame is discarded; 0 disables the timeout.
- `clk`  in  1  system clock.
- `nReset`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received byte from UART receiver.
- `rx_done`  in  1  one-cycle strobe: `rx_data` valid.
- `rx_err`  in  1  qualifies `rx_done`: byte had framing error.
- `tx_data`  out  8  byte to transmit.
- `tx_valid`  out  1  one-cycle strobe: start sending `tx_data`.
- `tx_busy`  in  1  transmitter busy.
- `tx_done`  in  1  one-cycle strobe: transmitter finished a byte.
- `bus_addr`  out  32  transaction address.
- `bus_wdata`  out  32  write data.
- `bus_wen`  out  1  write request.
- `bus_ren`  out  1  read request.
- `bus_rdata`  in  32  read data.
- `bus_request_stall`  in  1  target not ready; the transaction completes on the first cycle it is low.
- `bus_error`  in  1  sampled at completion.
- `active`  out  1  high whenever state ≠ IDLE.
- `dropped`  out  1  one-cycle pulse: an rx byte was ignored (arrived in BUS/RESP).

## Operation
- Frame format: command byte, then 4 address bytes MSB first. Write (`0x57`) adds 4 data bytes MSB first. Read is `0x52`.
- Response: ACK `0x06` on success. A read success is followed by 4 rdata bytes MSB first. NAK `0x15` (single byte) on bus error, unknown command, or `rx_err` mid-frame.
- States:
  - IDLE: on `rx_done`&&!`rx_err`: `0x57`/`0x52` → ADDR (latch op, byte count 0); other byte → RESP(NAK). `rx_err` in IDLE is ignored silently.
  - ADDR: shift byte into addr `{addr[23:0],byte}`. After the 4th byte, write → DATA, read → BUS.
  - DATA: shift into wdata the same way. After the 4th byte → BUS.
  - BUS: `bus_wen` or `bus_ren` high with `bus_addr`/`bus_wdata` stable. When `bus_request_stall`==0, capture `bus_rdata` and `bus_error`, then → RESP. A stall of any length is legal.
  - RESP: send the queued bytes (1 or 5), then → IDLE.
- `rx_err` in ADDR/DATA → RESP(NAK) and the partial frame is discarded.
- Inter-byte timeout in ADDR/DATA: counter resets on each `rx_done` and counts otherwise. On reaching `TimeoutCycles` → IDLE with no response.
- `rx_done` during BUS or RESP: byte is discarded and `dropped` pulses. There is no buffering.
- `bus_addr`/`bus_wdata` hold their last values after the transaction. They are not cleared.

## Timing
- Reset (async, immediate): state IDLE. All outputs 0: `tx_data`=0, `tx_valid`=0, `bus_addr`=0, `bus_wdata`=0, `bus_wen`=0, `bus_ren`=0, `active`=0, `dropped`=0. Counters and shift registers cleared.
- All outputs are registered.
- Bus request rises the cycle after the `rx_done` of the last frame byte.
- Bus request falls the cycle after the completion cycle, i.e. the first cycle with `bus_request_stall`=0 while requesting. Zero-stall transaction: request is high exactly 1 cycle.
- First `tx_valid` pulse: the cycle after BUS completion, or the cycle after the bad byte for NAK, provided `tx_busy`=0. Otherwise it waits for `tx_busy`=0.
- Subsequent bytes: `tx_valid` pulses the cycle after `tx_done`, gated by `tx_busy`=0. Never more than one outstanding byte.
- Return to IDLE: the cycle after `tx_done` of the last response byte. A new frame's command byte is accepted in that IDLE cycle or later.
- Timeout fires exactly `TimeoutCycles` cycles after the last `rx_done` with no further `rx_done`.

## Test plan
- Write: bytes `57 00 00 00 10 DE AD BE EF`, no stall → one cycle of `bus_wen`=1, addr `0x10`, wdata `0xDEADBEEF`; tx `06`; `active` low afterward.
- Read with 3 stall cycles: `52 00 00 00 08`, rdata `0x12345678` → `bus_ren` high 4 cycles; tx `06 12 34 56 78` in order, each `tx_valid` one cycle after the previous `tx_done`.
- Bus error on write → tx `15` only; next frame is processed normally.
- Unknown command `0x41` → tx `15`, no bus activity.
- `rx_err` on the 3rd address byte → tx `15`, no bus activity.
- With `TimeoutCycles`=50: stop after 2 address bytes → IDLE at cycle 50, no tx.
- Byte arriving during RESP → `dropped` pulses and the response is unchanged.
- Assert `nReset` during BUS → `bus_ren`/`bus_wen` low immediately and all outputs at their reset values.
